if_id_fifo: RTL

IF_ID_FIFO -- requirements
Module: if_id_fifo

---
 rtl/if_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 50 +++++
 rtl/if_id_fifo.sv | 121 ++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared fetch types, reset vector and log2 helper
package if_pkg;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with flush, wrap-bit pointers and occupancy count
module sync_fifo
    import if_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic [log2(DEPTH):0]   count
);

    localparam int AW = log2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/if_id_fifo.sv
// rtl/if_id_fifo.sv - fetch request generator and IF/ID instruction queue with redirect discard
module if_id_fifo #(
    parameter int          DEPTH    = 4,
    parameter int          BUS_W    = 64,
    parameter logic [31:0] RESET_PC = if_pkg::RESET_PC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             if_id_stall,
    input  logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_inst,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [31:0]      req_addr,
    input  logic             rsp_valid,
    input  logic [BUS_W-1:0] rsp_data,
    output logic             rsp_ready,
    output logic             if_idle
);

    localparam int AW   = if_pkg::log2(DEPTH);
    localparam int WSEL = if_pkg::log2(BUS_W / 32);
    localparam logic [AW+1:0] CREDIT_MAX = (AW + 2)'(DEPTH);

    logic [AW:0]            occupancy;
    logic [AW:0]            inflight;
    logic [AW:0]            discard_cnt;
    logic [AW+1:0]          credit;
    logic [31:0]            fetch_pc;
    logic [31:0]            rsp_pc;
    logic [31:0]            inst_sel;
    logic                   fire;
    logic                   rsp_take;
    logic                   rsp_drop;
    logic                   push;
    logic                   pop;
    logic                   inst_empty;
    logic                   pcq_empty;
    if_pkg::fetch_entry_t   push_entry;
    if_pkg::fetch_entry_t   head_entry;

    // Queued plus outstanding entries can never exceed the queue depth.
    assign credit    = {1'b0, occupancy} + {1'b0, inflight};
    assign req_valid = (credit < CREDIT_MAX) && (discard_cnt == '0) && !redirect_valid && !rst;
    assign req_addr  = fetch_pc;
    assign fire      = req_valid && req_ready;
    assign rsp_ready = 1'b1;

    assign rsp_drop  = rsp_valid && (discard_cnt != '0);
    assign rsp_take  = rsp_valid && (discard_cnt == '0) && !pcq_empty;
    assign push      = rsp_take && !redirect_valid;
    assign out_valid = !inst_empty;
    assign pop       = out_valid && in_ready && !if_id_stall && !redirect_valid;
    assign if_idle   = (inflight == '0) && (discard_cnt == '0);

    generate
        if (WSEL == 0) begin : g_bus32
            assign inst_sel = rsp_data[31:0];
        end else begin : g_bus_wide
            logic [WSEL-1:0] word_sel;
            assign word_sel = rsp_pc[2 +: WSEL];
            assign inst_sel = rsp_data[{word_sel, 5'b0} +: 32];
        end
    endgenerate

    assign push_entry.pc   = rsp_pc;
    assign push_entry.inst = inst_sel;
    assign out_pc          = out_valid ? head_entry.pc   : '0;
    assign out_inst        = out_valid ? head_entry.inst : '0;

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (fire),
        .push_data (fetch_pc),
        .pop       (rsp_take),
        .head      (rsp_pc),
        .empty     (pcq_empty),
        .count     (inflight)
    );

    sync_fifo #(.WIDTH($bits(if_pkg::fetch_entry_t)), .DEPTH(DEPTH)) u_inst_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .empty     (inst_empty),
        .count     (occupancy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
        end else if (fire) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // Everything still outstanding at a redirect becomes stale and must be dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            discard_cnt <= '0;
        end else if (redirect_valid) begin
            discard_cnt <= discard_cnt + inflight + {{AW{1'b0}}, fire}
                           - {{AW{1'b0}}, rsp_take | rsp_drop};
        end else if (rsp_drop) begin
            discard_cnt <= discard_cnt - 1'b1;
        end
    end

endmodule
